// File: rtl/shared_mem_responder.sv
// shared_mem_responder: round-robin arbiter serving per-core remote requests against a shared SRAM
module shared_mem_responder #(
    parameter int NUM_CORES   = 4,
    parameter int MEM_SIZE    = 4096,
    parameter int ADDR_WIDTH  = $clog2(MEM_SIZE),
    parameter int GRANT_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [16*NUM_CORES-1:0] req_addr,
    input  logic [NUM_CORES-1:0]   req_wren,
    input  logic [NUM_CORES-1:0]   req_rden,
    input  logic [16*NUM_CORES-1:0] req_write_val,
    output logic [NUM_CORES-1:0]   req_ready,
    output logic [15:0]            read_val
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_n;
    logic [GRANT_WIDTH-1:0] grant, grant_n, last_grant, last_grant_n, pick, idx;
    logic [NUM_CORES-1:0] req;
    logic [ADDR_WIDTH-1:0] addr_a [NUM_CORES];
    logic [15:0] data_a [NUM_CORES];
    logic [15:0] mem [MEM_SIZE];
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic wr_go, rd_go, found, take, unused_addr;
    assign req = req_rden | req_wren;
    genvar i;
    generate
        for (i = 0; i < NUM_CORES; i++) begin : g_core
            assign addr_a[i] = req_addr[16*i +: ADDR_WIDTH];
            assign data_a[i] = req_write_val[16*i +: 16];
        end
    endgenerate
    assign unused_addr = ^req_addr;
    assign cur_addr = addr_a[grant];
    assign take = (state == IDLE) && (|req);
    assign wr_go = (state == ACK) && req_wren[grant];
    assign rd_go = (state == ACK) && !req_wren[grant] && req_rden[grant];
    // round-robin search starting just after the last winner, wrapping around
    always_comb begin
        pick = last_grant;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = GRANT_WIDTH'((int'(last_grant) + k) % NUM_CORES);
            if (!found && req[idx]) begin
                pick = idx;
                found = 1'b1;
            end
        end
    end
    // next state, winner capture and ready decode from registered state only
    always_comb begin
        state_n = take ? ACK : IDLE;
        grant_n = take ? pick : grant;
        last_grant_n = take ? pick : last_grant;
        req_ready = (state == ACK) ? (NUM_CORES'(1) << grant) : '0;
    end
    // state register; reset leaves core 0 as top priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last_grant <= GRANT_WIDTH'(NUM_CORES - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            last_grant <= last_grant_n;
        end
    end
    // read data register only moves on the edge ending a read acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) read_val <= '0;
        else if (rd_go) read_val <= mem[cur_addr];
    end
    // SRAM write port; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (wr_go && !reset) mem[cur_addr] <= data_a[grant];
    end
endmodule

// File: tb/tb_shared_mem_responder.sv
// tb_shared_mem_responder: directed checks of arbitration order, latency, read data and reset behaviour
module tb_shared_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] req_addr;
    logic [3:0]  req_wren;
    logic [3:0]  req_rden;
    logic [63:0] req_write_val;
    logic [3:0]  req_ready;
    logic [15:0] read_val;
    int errors = 0;
    int checks = 0;

    shared_mem_responder dut (
        .clk(clk),
        .reset(reset),
        .req_addr(req_addr),
        .req_wren(req_wren),
        .req_rden(req_rden),
        .req_write_val(req_write_val),
        .req_ready(req_ready),
        .read_val(read_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d);
        req_wren[c] = wr;
        req_rden[c] = rd;
        req_addr[16*c +: 16] = a;
        req_write_val[16*c +: 16] = d;
    endtask

    task automatic req_one(input int c, input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d);
        set_req(c, wr, rd, a, d);
        tick();
        check("ready_pulse", {28'd0, req_ready}, 32'(4'b0001 << c));
        tick();
        req_wren[c] = 1'b0;
        req_rden[c] = 1'b0;
        check("ready_off", {28'd0, req_ready}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_addr = '0;
        req_wren = '0;
        req_rden = '0;
        req_write_val = '0;
        tick();
        tick();
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_read_val", {16'd0, read_val}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) set_req(c, 1'b0, 1'b1, 16'(16'h0100 + c), 16'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("rr_%0d", k), {28'd0, req_ready},
                  (k % 2 == 1) ? 32'(4'b0001 << (((k - 1) / 2) % 4)) : 32'd0);
        end
        req_rden = '0;
        tick();
        req_one(1, 1'b1, 1'b0, 16'h9004, 16'hBEEF);
        req_one(2, 1'b0, 1'b1, 16'h9004, 16'h0000);
        check("beef_read", {16'd0, read_val}, 32'hBEEF);
        req_one(3, 1'b1, 1'b0, 16'h1005, 16'h1234);
        req_one(0, 1'b0, 1'b1, 16'h0005, 16'h0000);
        check("alias_read", {16'd0, read_val}, 32'h1234);
        req_one(1, 1'b1, 1'b0, 16'h0020, 16'hAAAA);
        req_one(2, 1'b0, 1'b1, 16'h0020, 16'h0000);
        check("aaaa_read", {16'd0, read_val}, 32'hAAAA);
        req_one(0, 1'b1, 1'b0, 16'h0030, 16'h5555);
        check("hold_write", {16'd0, read_val}, 32'hAAAA);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_idle", {16'd0, read_val}, 32'hAAAA);
        end
        req_one(2, 1'b0, 1'b1, 16'h0030, 16'h0000);
        check("5555_read", {16'd0, read_val}, 32'h5555);
        set_req(0, 1'b0, 1'b1, 16'h0005, 16'h0000);
        set_req(3, 1'b0, 1'b1, 16'h0020, 16'h0000);
        tick();
        check("rot_first", {28'd0, req_ready}, 32'b1000);
        tick();
        req_rden[3] = 1'b0;
        check("rot_core3_data", {16'd0, read_val}, 32'hAAAA);
        tick();
        check("rot_second", {28'd0, req_ready}, 32'b0001);
        tick();
        req_rden[0] = 1'b0;
        check("rot_core0_data", {16'd0, read_val}, 32'h1234);
        req_one(1, 1'b1, 1'b1, 16'h0040, 16'h4242);
        check("rdwr_no_read", {16'd0, read_val}, 32'h1234);
        req_one(2, 1'b0, 1'b1, 16'h0040, 16'h0000);
        check("rdwr_written", {16'd0, read_val}, 32'h4242);
        set_req(3, 1'b0, 1'b1, 16'h0020, 16'h0000);
        tick();
        req_rden[3] = 1'b0;
        check("drop_ready", {28'd0, req_ready}, 32'b1000);
        tick();
        check("drop_read_val", {16'd0, read_val}, 32'h4242);
        req_one(0, 1'b1, 1'b0, 16'h0050, 16'h0101);
        set_req(2, 1'b1, 1'b0, 16'h0050, 16'h7777);
        tick();
        check("mid_ack_ready", {28'd0, req_ready}, 32'b0100);
        reset = 1'b1;
        #1;
        check("async_ready", {28'd0, req_ready}, 32'd0);
        check("async_read_val", {16'd0, read_val}, 32'd0);
        tick();
        req_wren[2] = 1'b0;
        reset = 1'b0;
        set_req(0, 1'b0, 1'b1, 16'h0050, 16'h0000);
        set_req(3, 1'b0, 1'b1, 16'h0020, 16'h0000);
        tick();
        check("post_rst_grant", {28'd0, req_ready}, 32'b0001);
        tick();
        req_rden = '0;
        check("no_write_on_rst", {16'd0, read_val}, 32'h0101);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
